axi_mem_responder: RTL and testbench

- AXI4 subordinate that terminates the CVA6 AXI manager port: 64-bit data, 64-bit address, 4-bit ID.
- Backed by a word-addressed SRAM array; handles single-beat and INCR/FIXED bursts.
- Used as the memory/peripheral end in core-level benches and small FPGA tiles.
- Independent read and write engines, each with one outstanding transaction.

---
 rtl/axi_mem_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a word-addressed 64-bit SRAM with independent read/write engines.
// Optional atomics rejection (SLVERR B plus a read beat for load-type ATOPs) under AXI_MEM_RESPONDER_ATOP_EN.
module axi_mem_responder #(
  parameter int unsigned          IdWidth   = 4,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          MemWords  = 4096,
  parameter logic [AddrWidth-1:0] BaseAddr  = 'h8000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic [2:0]             aw_size_i,
  input  logic [1:0]             aw_burst_i,
`ifdef AXI_MEM_RESPONDER_ATOP_EN
  input  logic [5:0]             aw_atop_i,
`endif
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  input  logic [2:0]             ar_size_i,
  input  logic [1:0]             ar_burst_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o
);

  localparam int unsigned          IdxW      = $clog2(MemWords);
  localparam int unsigned          StrbW     = DataWidth / 8;
  localparam logic [AddrWidth-1:0] SpanBytes = AddrWidth'(MemWords) << 3;
  localparam logic [1:0]           BURST_INCR = 2'b01;
  localparam logic [1:0]           BURST_WRAP = 2'b10;
  localparam logic [1:0]           RESP_OKAY  = 2'b00;
  localparam logic [1:0]           RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // Addresses below BaseAddr wrap to a huge offset, so one compare covers both bounds.
  function automatic logic f_in_range(input logic [AddrWidth-1:0] a);
    return (a - BaseAddr) < SpanBytes;
  endfunction

  function automatic logic [IdxW-1:0] f_idx(input logic [AddrWidth-1:0] a);
    return IdxW'((a - BaseAddr) >> 3);
  endfunction

  function automatic logic [AddrWidth-1:0] f_next(input logic [AddrWidth-1:0] a,
                                                  input logic [2:0] sz, input logic [1:0] bt);
    return (bt == BURST_INCR) ? a + (AddrWidth'(1) << sz) : a;
  endfunction

  logic [DataWidth-1:0] r_mem [MemWords];

  wstate_e              r_wstate;
  logic [IdWidth-1:0]   r_aw_id;
  logic [AddrWidth-1:0] r_aw_addr;
  logic [2:0]           r_aw_size;
  logic [1:0]           r_aw_burst;
  logic                 r_aw_atop;
  logic                 r_werr;

  rstate_e              r_rstate;
  logic [AddrWidth-1:0] r_ar_addr;
  logic [2:0]           r_ar_size;
  logic [1:0]           r_ar_burst;
  logic [7:0]           r_cnt;

  logic                 r_atop_pend;
  logic [IdWidth-1:0]   r_atop_id;

  logic                 w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic                 w_wbeat_err, w_mem_we;
  logic [IdxW-1:0]      w_widx;
  logic [AddrWidth-1:0] w_rnext_addr, w_raddr;
  logic [1:0]           w_rburst;
  logic                 w_rok;
  logic [DataWidth-1:0] w_rdata;
  logic                 w_atop_any, w_atop_rd, w_atop_set, w_atop_issue;
  logic                 w_unused;

  assign w_aw_hs = aw_valid_i & aw_ready_o;
  assign w_w_hs  = w_valid_i  & w_ready_o;
  assign w_b_hs  = b_valid_o  & b_ready_i;
  assign w_ar_hs = ar_valid_i & ar_ready_o;
  assign w_r_hs  = r_valid_o  & r_ready_i;

  // Beat count on the write side is governed by w_last alone.
  assign w_unused = ^aw_len_i;

`ifdef AXI_MEM_RESPONDER_ATOP_EN
  assign w_atop_any = (aw_atop_i != 6'd0);
  assign w_atop_rd  = w_atop_any && ((aw_atop_i[5:4] != 2'b01) ||
                                     (aw_atop_i == 6'h30) || (aw_atop_i == 6'h31));
`else
  assign w_atop_any = 1'b0;
  assign w_atop_rd  = 1'b0;
`endif

  assign w_atop_set   = w_aw_hs & w_atop_rd;
  assign w_atop_issue = (r_rstate == R_IDLE) & r_atop_pend & ~w_ar_hs;

  assign w_wbeat_err = (r_aw_burst == BURST_WRAP) | ~f_in_range(r_aw_addr) | r_aw_atop;
  assign w_mem_we    = w_w_hs & ~w_wbeat_err;
  assign w_widx      = f_idx(r_aw_addr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate   <= W_IDLE;
      aw_ready_o <= 1'b1;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      b_id_o     <= '0;
      b_resp_o   <= RESP_OKAY;
      r_aw_id    <= '0;
      r_aw_addr  <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_aw_atop  <= 1'b0;
      r_werr     <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_id    <= aw_id_i;
            r_aw_addr  <= aw_addr_i;
            r_aw_size  <= aw_size_i;
            r_aw_burst <= aw_burst_i;
            r_aw_atop  <= w_atop_any;
            r_werr     <= 1'b0;
            aw_ready_o <= 1'b0;
            w_ready_o  <= 1'b1;
            r_wstate   <= W_DATA;
          end else if (!aw_ready_o) begin
            aw_ready_o <= ~r_atop_pend;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_aw_addr <= f_next(r_aw_addr, r_aw_size, r_aw_burst);
            r_werr    <= r_werr | w_wbeat_err;
            if (w_last_i) begin
              w_ready_o <= 1'b0;
              b_valid_o <= 1'b1;
              b_id_o    <= r_aw_id;
              b_resp_o  <= (r_werr | w_wbeat_err) ? RESP_SLV : RESP_OKAY;
              r_wstate  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            b_valid_o  <= 1'b0;
            // A pending atomic read beat must drain before another AW is taken.
            aw_ready_o <= ~(r_atop_pend & ~w_atop_issue);
            r_wstate   <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (w_strb_i[b]) r_mem[w_widx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  // Single read port: AR address when idle, the advanced burst address otherwise.
  assign w_rnext_addr = f_next(r_ar_addr, r_ar_size, r_ar_burst);
  assign w_raddr      = (r_rstate == R_IDLE) ? ar_addr_i  : w_rnext_addr;
  assign w_rburst     = (r_rstate == R_IDLE) ? ar_burst_i : r_ar_burst;
  assign w_rok        = (w_rburst != BURST_WRAP) && f_in_range(w_raddr);
  assign w_rdata      = w_rok ? r_mem[f_idx(w_raddr)] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstate   <= R_IDLE;
      ar_ready_o <= 1'b1;
      r_valid_o  <= 1'b0;
      r_last_o   <= 1'b0;
      r_data_o   <= '0;
      r_resp_o   <= RESP_OKAY;
      r_id_o     <= '0;
      r_ar_addr  <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_ar_addr  <= ar_addr_i;
            r_ar_size  <= ar_size_i;
            r_ar_burst <= ar_burst_i;
            r_cnt      <= ar_len_i;
            r_id_o     <= ar_id_i;
            r_data_o   <= w_rdata;
            r_resp_o   <= w_rok ? RESP_OKAY : RESP_SLV;
            r_last_o   <= (ar_len_i == 8'd0);
            r_valid_o  <= 1'b1;
            ar_ready_o <= 1'b0;
            r_rstate   <= R_DATA;
          end else if (w_atop_issue) begin
            r_cnt      <= 8'd0;
            r_id_o     <= r_atop_id;
            r_data_o   <= '0;
            r_resp_o   <= RESP_SLV;
            r_last_o   <= 1'b1;
            r_valid_o  <= 1'b1;
            ar_ready_o <= 1'b0;
            r_rstate   <= R_DATA;
          end else begin
            ar_ready_o <= ~(r_atop_pend | w_atop_set);
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_cnt == 8'd0) begin
              r_valid_o  <= 1'b0;
              r_last_o   <= 1'b0;
              ar_ready_o <= ~(r_atop_pend | w_atop_set);
              r_rstate   <= R_IDLE;
            end else begin
              r_cnt     <= r_cnt - 8'd1;
              r_ar_addr <= w_rnext_addr;
              r_data_o  <= w_rdata;
              r_resp_o  <= w_rok ? RESP_OKAY : RESP_SLV;
              r_last_o  <= (r_cnt == 8'd1);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_atop_pend <= 1'b0;
      r_atop_id   <= '0;
    end else if (w_atop_set) begin
      r_atop_pend <= 1'b1;
      r_atop_id   <= aw_id_i;
    end else if (w_atop_issue) begin
      r_atop_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed + randomized bench for axi_mem_responder against a word-level memory model.
module tb_axi_mem_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          MW   = 4096;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        aw_valid_i, aw_ready_o;
  logic [3:0]  aw_id_i;
  logic [63:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [2:0]  aw_size_i;
  logic [1:0]  aw_burst_i;
`ifdef AXI_MEM_RESPONDER_ATOP_EN
  logic [5:0]  aw_atop_i;
`endif
  logic        w_valid_i, w_ready_o;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        w_last_i;
  logic        b_valid_o, b_ready_i;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i, ar_ready_o;
  logic [3:0]  ar_id_i;
  logic [63:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic        r_valid_o, r_ready_i;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;

  axi_mem_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i),
`ifdef AXI_MEM_RESPONDER_ATOP_EN
    .aw_atop_i(aw_atop_i),
`endif
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] mdl [int];
  logic [63:0] wdat [16];
  logic [7:0]  wstb [16];

  function automatic bit inr(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * MW));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_r(input logic [3:0] id, input logic [63:0] d, input logic [1:0] rs,
                       input bit last);
    chk("r_valid", r_valid_o, 1);
    chk("r_id",    r_id_o,    id);
    chk("r_data",  r_data_o,  d);
    chk("r_resp",  r_resp_o,  rs);
    chk("r_last",  r_last_o,  last);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [1:0] burst,
                          input logic [2:0] size, input int nb, input logic [5:0] atop);
    logic [63:0] a, t;
    bit          err, e, rdy;
    int          n;
    logic [1:0]  eresp;
    aw_valid_i = 1; aw_id_i = id; aw_addr_i = addr; aw_len_i = 8'(nb - 1);
    aw_size_i = size; aw_burst_i = burst;
`ifdef AXI_MEM_RESPONDER_ATOP_EN
    aw_atop_i = atop;
`endif
    n = 0;
    do begin rdy = aw_ready_o; cyc(); n++; end while (!rdy && n < 64);
    aw_valid_i = 0;
    chk("aw_handshake", rdy, 1);
    chk("w_ready_latency", w_ready_o, 1);
    a = addr; err = 0;
    for (int k = 0; k < nb; k++) begin
      w_valid_i = 1; w_data_i = wdat[k]; w_strb_i = wstb[k]; w_last_i = (k == nb - 1);
      n = 0;
      do begin rdy = w_ready_o; cyc(); n++; end while (!rdy && n < 64);
      chk("w_handshake", rdy, 1);
      e = (burst == 2'b10) || !inr(a) || (atop != 6'd0);
      if (!e) begin
        t = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'd0;
        for (int b = 0; b < 8; b++) if (wstb[k][b]) t[8*b +: 8] = wdat[k][8*b +: 8];
        mdl[widx(a)] = t;
      end
      err = err | e;
      if (burst == 2'b01) a = a + (64'd1 << size);
    end
    w_valid_i = 0; w_last_i = 0;
    eresp = err ? 2'b10 : 2'b00;
    chk("b_valid_latency", b_valid_o, 1);
    chk("w_ready_drop", w_ready_o, 0);
    n = $urandom_range(0, 2);
    for (int s = 0; s < n; s++) begin
      chk("b_hold_valid", b_valid_o, 1);
      chk("b_hold_id", b_id_o, id);
      chk("b_hold_resp", b_resp_o, eresp);
      cyc();
    end
    b_ready_i = 1;
    chk("b_id", b_id_o, id);
    chk("b_resp", b_resp_o, eresp);
    cyc();
    b_ready_i = 0;
    chk("b_valid_drop", b_valid_o, 0);
    chk("aw_ready_back", aw_ready_o, 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int stall0,
                         input bit rnd);
    logic [63:0] a, ed;
    bit          e, rdy;
    int          n, st;
    ar_valid_i = 1; ar_id_i = id; ar_addr_i = addr; ar_len_i = len;
    ar_size_i = size; ar_burst_i = burst;
    n = 0;
    do begin rdy = ar_ready_o; cyc(); n++; end while (!rdy && n < 64);
    ar_valid_i = 0;
    chk("ar_handshake", rdy, 1);
    a = addr;
    for (int k = 0; k <= int'(len); k++) begin
      e  = (burst == 2'b10) || !inr(a);
      ed = e ? 64'd0 : mdl[widx(a)];
      st = (k == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
      r_ready_i = 0;
      for (int s = 0; s < st; s++) begin
        chk_r(id, ed, e ? 2'b10 : 2'b00, k == int'(len));
        cyc();
      end
      r_ready_i = 1;
      chk_r(id, ed, e ? 2'b10 : 2'b00, k == int'(len));
      cyc();
      if (burst == 2'b01) a = a + (64'd1 << size);
    end
    r_ready_i = 0;
    chk("r_valid_drop", r_valid_o, 0);
    chk("ar_ready_back", ar_ready_o, 1);
  endtask

  logic [63:0] ra;
  int          nb, wi;
  logic [1:0]  bt;
  logic [2:0]  sz;

  initial begin
    rst_i = 1;
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0; aw_burst_i = 0;
`ifdef AXI_MEM_RESPONDER_ATOP_EN
    aw_atop_i = 0;
`endif
    w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0; b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
    r_ready_i = 0;
    repeat (3) cyc();
    rst_i = 0;
    cyc();

    chk("rst_aw_ready", aw_ready_o, 1);
    chk("rst_ar_ready", ar_ready_o, 1);
    chk("rst_w_ready",  w_ready_o,  0);
    chk("rst_b_valid",  b_valid_o,  0);
    chk("rst_r_valid",  r_valid_o,  0);
    chk("rst_r_last",   r_last_o,   0);
    chk("rst_r_data",   r_data_o,   0);
    chk("rst_b_id",     b_id_o,     0);
    chk("rst_r_id",     r_id_o,     0);
    chk("rst_b_resp",   b_resp_o,   0);
    chk("rst_r_resp",   r_resp_o,   0);

    // Preload low words and the top of the array with known data.
    wstb[0] = 8'hFF;
    for (int i = 0; i < 36; i++) begin
      wi = (i < 32) ? i : MW - 36 + i;
      wdat[0] = {$urandom, $urandom};
      do_write(4'($urandom), BASE + 64'(8 * wi), 2'b01, 3'd3, 1, 6'd0);
    end

    wdat[0] = 64'hDEADBEEF_CAFEF00D; wstb[0] = 8'hFF;
    do_write(4'h5, 64'h8000_0010, 2'b01, 3'd3, 1, 6'd0);
    do_read(4'h6, 64'h8000_0010, 8'd0, 2'b01, 3'd3, 0, 0);

    do_read(4'h2, BASE, 8'd3, 2'b01, 3'd3, 5, 0);

    wdat[0] = 64'hAAAAAAAA_BBBBBBBB; wstb[0] = 8'hFF;
    do_write(4'h1, BASE, 2'b01, 3'd3, 1, 6'd0);
    wdat[0] = 64'h11111111_22222222; wstb[0] = 8'h0F;
    do_write(4'h1, BASE, 2'b01, 3'd3, 1, 6'd0);
    do_read(4'h1, BASE, 8'd0, 2'b01, 3'd3, 0, 0);
    chk("strb_merge", r_data_o, 64'hAAAAAAAA_22222222);

    do_read(4'h7, 64'h7FFF_FFF8, 8'd1, 2'b00, 3'd3, 1, 0);

    for (int k = 0; k < 4; k++) begin wdat[k] = {$urandom, $urandom}; wstb[k] = 8'hFF; end
    do_write(4'hA, BASE + 64'h40, 2'b10, 3'd3, 4, 6'd0);
    do_read(4'hA, BASE + 64'h40, 8'd3, 2'b01, 3'd3, 0, 0);

    do_read(4'hB, BASE + 64'(8 * (MW - 2)), 8'd3, 2'b01, 3'd3, 0, 1);
    wdat[0] = 64'h0123_4567_89AB_CDEF; wdat[1] = 64'hFEDC_BA98_7654_3210;
    wstb[0] = 8'hFF; wstb[1] = 8'hFF;
    do_write(4'hC, BASE + 64'(8 * (MW - 1)), 2'b01, 3'd3, 2, 6'd0);
    do_read(4'hC, BASE + 64'(8 * (MW - 1)), 8'd0, 2'b01, 3'd3, 0, 0);

    // Reset in the middle of an 8-beat read.
    ar_valid_i = 1; ar_id_i = 4'h3; ar_addr_i = BASE + 64'h80; ar_len_i = 8'd7;
    ar_size_i = 3'd3; ar_burst_i = 2'b01;
    cyc();
    ar_valid_i = 0;
    r_ready_i = 1;
    for (int k = 0; k < 2; k++) begin
      chk_r(4'h3, mdl[16 + k], 2'b00, 0);
      cyc();
    end
    r_ready_i = 0;
    chk_r(4'h3, mdl[18], 2'b00, 0);
    #2 rst_i = 1;
    #1;
    chk("midrst_r_valid", r_valid_o, 0);
    chk("midrst_r_last",  r_last_o,  0);
    chk("midrst_r_data",  r_data_o,  0);
    chk("midrst_ar_ready", ar_ready_o, 1);
    cyc();
    rst_i = 0;
    r_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      chk("postrst_r_valid", r_valid_o, 0);
      chk("postrst_ar_ready", ar_ready_o, 1);
      cyc();
    end
    r_ready_i = 0;

    for (int it = 0; it < 30; it++) begin
      wi = $urandom_range(0, 28);
      bt = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
      sz = ($urandom_range(0, 3) == 0) ? 3'd2 : 3'd3;
      ra = BASE + 64'(8 * wi) + ((sz == 3'd2 && $urandom_range(0, 1) == 1) ? 64'd4 : 64'd0);
      nb = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < nb; k++) begin
          wdat[k] = {$urandom, $urandom}; wstb[k] = 8'($urandom);
        end
        do_write(4'($urandom), ra, bt, sz, nb, 6'd0);
      end else begin
        do_read(4'($urandom), ra, 8'(nb - 1), bt, sz, $urandom_range(0, 3), 1);
      end
    end

`ifdef AXI_MEM_RESPONDER_ATOP_EN
    wdat[0] = {$urandom, $urandom}; wstb[0] = 8'hFF;
    do_write(4'h9, BASE + 64'h28, 2'b01, 3'd3, 1, 6'h20);
    chk_r(4'h9, 64'd0, 2'b10, 1);
    chk("atop_ar_blocked", ar_ready_o, 0);
    r_ready_i = 1;
    cyc();
    r_ready_i = 0;
    chk("atop_r_drop", r_valid_o, 0);
    chk("atop_ar_back", ar_ready_o, 1);
    do_read(4'h9, BASE + 64'h28, 8'd0, 2'b01, 3'd3, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, expected summary before time limit");
    $fatal(1, "watchdog");
  end
endmodule
